// File: rtl/timer_multi_cpu.sv
// timer_multi_cpu: NumChannels independent 32-bit down-counters on a
// 6502-style register bus, all fed from one shared prescaled tick.
//   clk_i, reset_ni      : system clock, async active-low reset
//   address_i, rd_wr_i   : register address, 1 = write / 0 = read (every cycle)
//   data_i / data_o      : write data / registered read data (bits [7:0] used)
//   irq_o                : registered OR over channels of (done & irq_en)
// Per channel (base = BaseAddress + 4*n*Address_Wording, stride Address_Wording):
//   +0 RELOAD (W, byte shift-in MSB first), +1 CTRL (W), +2 STATUS (R), +3 COUNT (R)

// One timer channel. Strobes come pre-decoded from the top.
module timer_multi_cpu_ch (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       tick,
  input  logic       wr_reload,
  input  logic       wr_ctrl,
  input  logic       rd_status,
  input  logic       rd_count,
  input  logic [7:0] wdata,
  output logic [7:0] status,
  output logic [7:0] count_msb,
  output logic       irq_req
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state;
  logic [31:0] reload, count, shadow;
  logic        periodic, irq_en, done, overrun;
  logic        start, stop, done_evt;

  // stop dominates start when both bits are written together
  assign stop  = wr_ctrl & wdata[1];
  assign start = wr_ctrl & wdata[0] & ~wdata[1];
  // a start/stop write on the expiry tick pre-empts the done event
  assign done_evt = (state == RUN) & tick & (count == 32'd0) & ~start & ~stop;

  assign status    = {4'b0, (state == RUN), periodic, overrun, done};
  assign count_msb = shadow[31:24];
  assign irq_req   = done & irq_en;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= IDLE;
      reload   <= '0;
      count    <= '0;
      shadow   <= '0;
      periodic <= 1'b0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (wr_reload) reload <= {reload[23:0], wdata};
      if (wr_ctrl) begin
        periodic <= wdata[2];
        irq_en   <= wdata[3];
      end

      if (stop) begin
        state <= IDLE;
      end else if (start) begin
        state <= RUN;
        count <= reload;
      end else if (state == RUN && tick) begin
        if (count != 32'd0) count <= count - 32'd1;
        else if (periodic)  count <= reload;
        else begin
          state <= IDLE;
          count <= '0;
        end
      end

      // a coincident done event survives the clearing read; overrun does not
      if (rd_status) begin
        done    <= done_evt;
        overrun <= 1'b0;
        shadow  <= count;
      end else begin
        if (done_evt) begin
          done <= 1'b1;
          if (done) overrun <= 1'b1;
        end
        if (rd_count) shadow <= shadow << 8;
      end
    end
  end
endmodule

module timer_multi_cpu #(
  parameter int BaseAddress     = 0,
  parameter int FPGAClkSpeed    = 0,
  parameter int TimerClkSpeed   = 0,
  parameter int NumChannels     = 2,
  parameter int address_width   = 16,
  parameter int data_width      = 8,
  parameter int Address_Wording = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  output logic [data_width-1:0]    data_o,
  input  logic                     rd_wr_i,
  output logic                     irq_o
);
  localparam int Div = (TimerClkSpeed > 0) ? FPGAClkSpeed / TimerClkSpeed : 0;
  localparam int PW  = (Div > 1) ? $clog2(Div) : 1;

  if (Div < 1) begin : g_bad_div
    $error("timer_multi_cpu: FPGAClkSpeed/TimerClkSpeed must be at least 1");
  end
  if (NumChannels < 1 || NumChannels > 8) begin : g_bad_nch
    $error("timer_multi_cpu: NumChannels must be in 1..8");
  end

  // shared free-running prescaler; not resynchronised by channel starts
  logic [PW-1:0] presc;
  logic          tick;
  assign tick = (presc == PW'(Div - 1));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) presc <= '0;
    else           presc <= tick ? '0 : presc + 1'b1;
  end

  logic [NumChannels-1:0]       wr_reload, wr_ctrl, rd_status, rd_count, irq_req;
  logic [NumChannels-1:0][7:0]  status, count_msb;

  for (genvar n = 0; n < NumChannels; n++) begin : g_ch
    localparam int Base = BaseAddress + 4 * n * Address_Wording;

    assign wr_reload[n] =  rd_wr_i & (address_i == address_width'(Base));
    assign wr_ctrl[n]   =  rd_wr_i & (address_i == address_width'(Base + Address_Wording));
    assign rd_status[n] = ~rd_wr_i & (address_i == address_width'(Base + 2 * Address_Wording));
    assign rd_count[n]  = ~rd_wr_i & (address_i == address_width'(Base + 3 * Address_Wording));

    timer_multi_cpu_ch u_ch (
      .clk_i     (clk_i),
      .reset_ni  (reset_ni),
      .tick      (tick),
      .wr_reload (wr_reload[n]),
      .wr_ctrl   (wr_ctrl[n]),
      .rd_status (rd_status[n]),
      .rd_count  (rd_count[n]),
      .wdata     (data_i[7:0]),
      .status    (status[n]),
      .count_msb (count_msb[n]),
      .irq_req   (irq_req[n])
    );
  end

  // at most one strobe is active, so OR-ing is a mux; unmapped reads give 0
  logic [7:0] rd_byte;
  always_comb begin
    rd_byte = '0;
    for (int n = 0; n < NumChannels; n++) begin
      if (rd_status[n]) rd_byte = rd_byte | status[n];
      if (rd_count[n])  rd_byte = rd_byte | count_msb[n];
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      data_o <= '0;
      irq_o  <= 1'b0;
    end else begin
      if (!rd_wr_i) data_o <= data_width'(rd_byte);
      irq_o <= |irq_req;
    end
  end
endmodule

// File: tb/tb_timer_multi_cpu.sv
module tb_timer_multi_cpu;
  localparam int BASE = 16;
  localparam int NCH  = 2;
  localparam int DIV  = 4;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b1;
  logic [15:0] address = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_o;
  logic        rd_wr = 1'b0;
  logic        irq_o;

  timer_multi_cpu #(
    .BaseAddress(BASE), .FPGAClkSpeed(40), .TimerClkSpeed(10), .NumChannels(NCH),
    .address_width(16), .data_width(8), .Address_Wording(1)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni), .address_i(address), .data_i(data_in),
    .data_o(data_o), .rd_wr_i(rd_wr), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] d;
    logic       irq;
    bit         hc;
    logic [7:0] cv;
    string      nm;
  } exp_t;
  exp_t q[$];

  // reference model: state of each channel between clock edges
  logic [31:0] m_rel[NCH], m_cnt[NCH], m_sh[NCH];
  bit          m_run[NCH], m_per[NCH], m_ien[NCH], m_dn[NCH], m_ov[NCH];
  int          m_presc;
  logic [7:0]  m_do;
  bit          m_irq;
  bit          in_rst = 1'b0;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_rel[c] = 0; m_cnt[c] = 0; m_sh[c] = 0;
      m_run[c] = 0; m_per[c] = 0; m_ien[c] = 0; m_dn[c] = 0; m_ov[c] = 0;
    end
    m_presc = 0; m_do = 0; m_irq = 0;
  endfunction

  function automatic logic [7:0] status_of(int c);
    return {4'b0, m_run[c], m_per[c], m_ov[c], m_dn[c]};
  endfunction

  // advance the model across one clock edge given the bus cycle in flight
  function automatic void model_step(bit wr, int addr, logic [7:0] d);
    bit tick;
    int off, ch, r;
    bit irq_n;
    tick = (m_presc == DIV - 1);
    off = addr - BASE;
    ch = -1; r = 0;
    if (off >= 0 && off < 4 * NCH) begin ch = off / 4; r = off % 4; end
    irq_n = 0;
    for (int c = 0; c < NCH; c++) irq_n |= m_dn[c] & m_ien[c];
    if (!wr) begin
      if (ch >= 0 && r == 2)      m_do = status_of(ch);
      else if (ch >= 0 && r == 3) m_do = m_sh[ch][31:24];
      else                        m_do = 8'h00;
    end
    for (int c = 0; c < NCH; c++) begin
      bit sel, ctl, start, stop, ev, old_per;
      logic [31:0] old_rel, old_cnt;
      sel = (ch == c);
      ctl = wr && sel && r == 1;
      start = ctl && d[0] && !d[1];
      stop = ctl && d[1];
      ev = 0;
      old_rel = m_rel[c]; old_cnt = m_cnt[c]; old_per = m_per[c];
      if (stop) m_run[c] = 0;
      else if (start) begin m_run[c] = 1; m_cnt[c] = old_rel; end
      else if (m_run[c] && tick) begin
        if (old_cnt > 0) m_cnt[c] = old_cnt - 1;
        else begin
          ev = 1;
          if (old_per) m_cnt[c] = old_rel;
          else begin m_run[c] = 0; m_cnt[c] = 0; end
        end
      end
      if (ctl) begin m_per[c] = d[2]; m_ien[c] = d[3]; end
      if (wr && sel && r == 0) m_rel[c] = (old_rel << 8) | 32'(d);
      if (!wr && sel && r == 2) begin
        m_sh[c] = old_cnt; m_ov[c] = 0; m_dn[c] = ev;
      end else begin
        if (ev) begin
          if (m_dn[c]) m_ov[c] = 1;
          m_dn[c] = 1;
        end
        if (!wr && sel && r == 3) m_sh[c] = m_sh[c] << 8;
      end
    end
    m_presc = tick ? 0 : m_presc + 1;
    m_irq = irq_n;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor: every edge updates data_o/irq_o, compare just after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("data_o", data_o, e.d);
        check("irq_o", {7'b0, irq_o}, {7'b0, e.irq});
        if (e.hc) check(e.nm, data_o, e.cv);
      end
    end
  end

  task automatic cyc(input bit wr, input int addr, input logic [7:0] d,
                     input bit hc, input logic [7:0] cv, input string nm);
    exp_t e;
    @(negedge clk);
    rd_wr = wr; address = 16'(addr); data_in = d;
    if (in_rst) begin e.d = 8'h00; e.irq = 1'b0; end
    else begin model_step(wr, addr, d); e.d = m_do; e.irq = m_irq; end
    e.hc = hc; e.cv = cv; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic wr(input int addr, input logic [7:0] d); cyc(1, addr, d, 0, 8'h00, ""); endtask
  task automatic rd(input int addr); cyc(0, addr, 8'h00, 0, 8'h00, ""); endtask
  task automatic rdc(input int addr, input logic [7:0] cv, input string nm); cyc(0, addr, 8'h00, 1, cv, nm); endtask
  task automatic idle(input int n); repeat (n) rd(0); endtask
  task automatic set_reload(input int ch, input logic [31:0] v);
    for (int i = 3; i >= 0; i--) wr(BASE + 4 * ch, v[i*8 +: 8]);
  endtask

  task automatic release_rst();
    exp_t e;
    @(negedge clk);
    reset_ni = 1'b1; in_rst = 1'b0;
    rd_wr = 1'b0; address = '0; data_in = '0;
    model_step(0, 0, 8'h00);
    e.d = m_do; e.irq = m_irq; e.hc = 0; e.cv = 0; e.nm = "";
    q.push_back(e);
  endtask

  localparam int RL0 = BASE, CT0 = BASE + 1, ST0 = BASE + 2, CN0 = BASE + 3;
  localparam int RL1 = BASE + 4, CT1 = BASE + 5, ST1 = BASE + 6;

  initial begin
    bit found;
    int kind, ch, a;
    logic [7:0] cval;
    int unm[4];
    unm[0] = 0; unm[1] = BASE - 1; unm[2] = BASE + 4 * NCH; unm[3] = 16'hFFFF;

    model_reset();
    #1 reset_ni = 1'b0; in_rst = 1'b1;
    #1;
    check("reset_data_o", data_o, 8'h00);
    check("reset_irq_o", {7'b0, irq_o}, 8'h00);
    repeat (3) rd(0);
    release_rst();

    // one-shot, reload 3
    set_reload(0, 32'd3);
    wr(CT0, 8'h01);
    rdc(ST0, 8'h08, "oneshot_running");
    idle(20);
    rdc(ST0, 8'h01, "oneshot_done");
    rdc(ST0, 8'h00, "oneshot_cleared");
    rdc(BASE + 4 * NCH, 8'h00, "unmapped_read");

    // periodic with irq, overrun after two unread periods
    set_reload(1, 32'd2);
    wr(CT1, 8'h0D);
    idle(30);
    rdc(ST1, 8'h0F, "overrun_status");
    idle(3);
    wr(CT1, 8'h02);
    rd(ST1);
    idle(2);

    // live count snapshot, MSB first
    set_reload(0, 32'h0001_0000);
    wr(CT0, 8'h01);
    idle(10);
    rdc(ST0, 8'h08, "snap_status");
    rdc(CN0, 8'h00, "snap_b3");
    rdc(CN0, 8'h00, "snap_b2");
    rdc(CN0, 8'hFF, "snap_b1");
    rd(CN0);
    idle(8);

    // stop wins over start, count frozen, restart from reload
    set_reload(0, 32'd100);
    wr(CT0, 8'h01);
    idle(40);
    wr(CT0, 8'h03);
    idle(20);
    rdc(ST0, 8'h00, "stopped_status");
    repeat (4) rd(CN0);
    wr(CT0, 8'h01);
    rdc(ST0, 8'h08, "restart_status");
    rdc(CN0, 8'h00, "restart_b3");
    rdc(CN0, 8'h00, "restart_b2");
    rdc(CN0, 8'h00, "restart_b1");
    rdc(CN0, 8'h64, "restart_b0");
    wr(CT0, 8'h02);

    // done event coincident with a STATUS read
    set_reload(1, 32'd2);
    wr(CT1, 8'h05);
    rd(ST1);
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (m_run[1] && m_cnt[1] == 0 && m_presc == DIV - 1) begin
        rdc(ST1, 8'h0C, "coinc_read");
        found = 1;
      end else idle(1);
    end
    if (!found) begin
      n_tests++; n_fail++;
      $display("FAIL coinc_search: got no expiry edge within 60 cycles, expected one");
    end
    rdc(ST1, 8'h0D, "coinc_done_kept");
    rdc(ST1, 8'h0C, "coinc_cleared");

    // async reset mid-period with data_o and irq live
    wr(CT1, 8'h0D);
    idle(17);
    rd(ST1);
    wr(0, 8'hAA);
    #2 reset_ni = 1'b0;
    model_reset(); q.delete(); in_rst = 1'b1;
    #1;
    check("async_rst_data_o", data_o, 8'h00);
    check("async_rst_irq_o", {7'b0, irq_o}, 8'h00);
    repeat (2) rd(0);
    release_rst();
    idle(30);
    rdc(ST0, 8'h00, "post_rst_st0");
    rdc(ST1, 8'h00, "post_rst_st1");
    rdc(CN0, 8'h00, "post_rst_cnt0");

    // randomized traffic
    for (int i = 0; i < 700; i++) begin
      kind = $urandom_range(0, 9);
      ch = $urandom_range(0, NCH - 1);
      a = BASE + 4 * ch;
      case (kind)
        0, 1: wr(a, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 6)) : 8'h00);
        2: begin
          cval = 8'($urandom_range(0, 15));
          if (cval[1] && $urandom_range(0, 2) != 0) cval[1] = 1'b0;
          wr(a + 1, cval);
        end
        3, 4: rd(a + 2);
        5: rd(a + 3);
        6: rd(unm[$urandom_range(0, 3)]);
        7: wr(unm[$urandom_range(0, 3)], 8'($urandom_range(0, 255)));
        default: idle(1);
      endcase
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
